// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Consumed by nibble_serial_adder via import nibble_serial_adder_pkg::*.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } nsa_state_t;

  function automatic int nsa_nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/bit_4_ripple_carry.sv
// Existing 4-bit ripple-carry adder stage.
// Combinational; reused once per nibble by the serial adder.
module bit_4_ripple_carry (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_0,
  output logic [3:0] s,
  output logic       c_4
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_0;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_4 = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder, one nibble per clock through a single 4-bit stage.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to enable signed overflow on ovf.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N     = nsa_nibbles(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = (N > 1) ? WIDTH - NIBBLE_W : 1;

  if ((WIDTH < NIBBLE_W) || (WIDTH % NIBBLE_W != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  nsa_state_t       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cy_q;
  logic [IDX_W-1:0] idx_q;
  logic [ACC_W-1:0] acc_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;

  logic [3:0]       s4;
  logic             c4;
  logic [WIDTH-1:0] acc_nx;
  logic             last;

  bit_4_ripple_carry u_rca (
    .a   (a_q[3:0]),
    .b   (b_q[3:0]),
    .c_0 (cy_q),
    .s   (s4),
    .c_4 (c4)
  );

  // New nibble enters at the top; after N steps it has reached bit 0.
  if (N > 1) begin : g_acc
    assign acc_nx = {s4, acc_q};
  end else begin : g_acc1
    assign acc_nx = s4;
  end

  assign last = (idx_q == IDX_W'(N - 1));

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            cy_q    <= c_in;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_nx[WIDTH-1 -: ACC_W];
          cy_q  <= c4;
          a_q   <= a_q >> NIBBLE_W;
          b_q   <= b_q >> NIBBLE_W;
          idx_q <= idx_q + IDX_W'(1);
          if (last) begin
            sum_q   <= acc_nx;
            c_out_q <= c4;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q <= (a_msb_q == b_msb_q) &&
                     (acc_nx[WIDTH-1] != a_msb_q);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed scoreboard bench for nibble_serial_adder at WIDTH=16.
// Expected ovf follows NIBBLE_SERIAL_ADDER_OVF_EN, as does the DUT.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q[$];
  exp_t prev;
  int   total;
  int   passed;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] av, bv,
                                 input logic ci);
    exp_t        e;
    logic [16:0] r;
    r   = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
    e.s = r[15:0];
    e.c = r[16];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    e.o = (av[15] == bv[15]) && (r[15] != av[15]);
`else
    e.o = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic collect();
    exp_t e;
    chk("sb_nonempty", 32'(q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sum", 32'(sum), 32'(e.s));
      chk("c_out", 32'(c_out), 32'(e.c));
      chk("ovf", 32'(ovf), 32'(e.o));
      prev = e;
    end
  endtask

  task automatic run_op(input logic [15:0] av, bv, input logic ci);
    int cyc;
    int bcnt;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    c_in  = ci;
    q.push_back(model(av, bv, ci));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("hold_sum", 32'(sum), 32'(prev.s));
    chk("hold_cout", 32'(c_out), 32'(prev.c));
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, 4);
    chk("busy_cycles", bcnt, 4);
    chk("busy_low_at_done", 32'(busy), 0);
    collect();
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int cyc;
    total  = 0;
    passed = 0;
    prev   = '{s: 16'h0, c: 1'b0, o: 1'b0};
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    c_in   = 1'b0;

    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(c_out), 0);
    chk("rst_ovf", 32'(ovf), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1);

    // start held through RUN with noisy operands, then re-accepted in DONE
    @(negedge clk);
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h4321;
    c_in  = 1'b0;
    q.push_back(model(16'h1234, 16'h4321, 1'b0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      #1;
    end
    chk("b2b_first_done", 32'(done), 1);
    collect();
    a = 16'h0F0F;
    b = 16'h00F1;
    q.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_done_drop", 32'(done), 0);
    chk("b2b_busy", 32'(busy), 1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 2) begin
        chk("b2b_hold_sum", 32'(sum), 32'h5555);
        chk("b2b_hold_cout", 32'(c_out), 0);
      end
    end
    chk("b2b_gap", cyc + 1, 5);
    collect();
    chk("b2b_sum_lit", 32'(sum), 32'h1000);

    // reset during the second RUN cycle
    @(negedge clk);
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(c_out), 0);
    chk("abort_ovf", 32'(ovf), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev  = '{s: 16'h0, c: 1'b0, o: 1'b0};
    run_op(16'h0001, 16'h0001, 1'b0);
    chk("post_rst_sum", 32'(sum), 32'h0002);

    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b0);
    run_op(16'hBEEF, 16'h4111, 1'b1);

    chk("sb_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
